dmem_cache: RTL and testbench
=============================

DMEM_CACHE -- requirements
Module: dmem_cache

Interface
REQ-001 Parameter LINES, default 64, number of one-word direct-mapped lines; power of 2 and at least 2; IDX = log2(LINES).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 cpu_addr  input  32  byte address from core; bits [1:0] ignored.
REQ-005 cpu_re  input  1  read request.
REQ-006 cpu_we  input  4  byte write mask; nonzero = write request.
REQ-007 cpu_din  input  32  store data, byte lanes aligned to the mask.
REQ-008 cpu_dout  output  32  load data, registered.
REQ-009 stall  output  1  core holds its request and pipeline while high.
REQ-010 mem_req_valid  output  1  main-memory request valid.
REQ-011 mem_req_ready  input  1  main memory accepts the request this cycle.
REQ-012 mem_req_rw  output  1  1 = write, 0 = read.
REQ-013 mem_req_addr  output  30  word address, cpu_addr[31:2].
REQ-014 mem_req_data  output  32  write data, cpu_din.
REQ-015 mem_req_mask  output  4  write byte mask, cpu_we.
REQ-016 mem_resp_valid  input  1  read data valid, exactly 1 cycle per read.
REQ-017 mem_resp_data  input  32  read data.

Function
REQ-018 Array: LINES entries of {valid, tag[31:2+IDX], data[31:0]}; index = cpu_addr[1+IDX:2].
REQ-019 Hit = valid[index] and tag[index] == cpu_addr[31:2+IDX]; evaluated combinationally on the current inputs.
REQ-020 Request = cpu_re or (cpu_we != 0); if both are set, the request is a write; cpu_re is ignored.
REQ-021 States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-022 In IDLE, stall = request and not (read and hit); stall = 1 in RD_REQ, RD_WAIT and WR_REQ; stall = 0 in DONE.
REQ-023 IDLE, read hit: cpu_dout <= data[index] at the edge; stay in IDLE; zero-stall back-to-back hits are allowed.
REQ-024 IDLE, read miss: go to RD_REQ. IDLE, write: go to WR_REQ. No request: stay in IDLE with cpu_dout held.
REQ-025 RD_REQ: mem_req_valid = 1, mem_req_rw = 0; on mem_req_ready go to RD_WAIT.
REQ-026 RD_WAIT: on mem_resp_valid, write {1, tag, mem_resp_data} into the line, set cpu_dout <= mem_resp_data, and go to DONE.
REQ-027 WR_REQ (write-through, no-write-allocate): mem_req_valid = 1, mem_req_rw = 1, with mask and data from the core.
REQ-028 WR_REQ, on mem_req_ready: if the line hits, merge the masked bytes of cpu_din into the line data; a miss leaves the array unchanged; then go to DONE.
REQ-029 DONE lasts exactly 1 cycle: stall = 0 so the core retires the request; the inputs are ignored; go to IDLE.
REQ-030 The core holds its address, data and control stable while stall = 1; the block latches nothing from those inputs across states.
REQ-031 mem_req_valid, once asserted, stays high with stable fields until mem_req_ready; it is 0 in IDLE and DONE.
REQ-032 Latency, in cycles from request to the stall-low retiring edge: read hit 0; read miss 1 + ready wait + response wait + 1; write 1 + ready wait + 1.
REQ-033 mem_resp_valid outside RD_WAIT is ignored. mem_req_ready asserted in the same cycle as the request is legal: the state advances on that edge.

Reset
REQ-034 When reset is high at an edge: state = IDLE, every valid bit = 0, cpu_dout = 0; tag and data contents are don't-care.
REQ-035 While in IDLE after reset with no request: stall = 0, mem_req_valid = 0.
REQ-036 Reset mid-operation (RD_REQ, RD_WAIT or WR_REQ) abandons the transaction: no line is filled, and mem_req_valid = 0 from the next cycle.

Verification
REQ-037 Reset, then read 0x0000_0100 with ready=1 and response 0xDEAD_BEEF 2 cycles later: stall high 4 cycles, cpu_dout = 0xDEAD_BEEF, mem_req_addr = 0x40.
REQ-038 Re-read 0x0000_0100 twice back-to-back: stall stays 0, no mem_req_valid, cpu_dout = 0xDEAD_BEEF on each following cycle.
REQ-039 Write 0x0000_0100 with we=4'b0011, din=0x0000_1234, ready held low 3 cycles: mem_req_valid high 4 cycles with fields stable; a subsequent read hit returns 0xDEAD_1234.
REQ-040 With LINES=64, read 0x0000_0200 (same index, different tag): miss and line replaced; re-read 0x0000_0100 misses again.
REQ-041 Assert reset while in RD_WAIT, then deliver mem_resp_valid: no fill; a read of that address misses; stall = 0 after reset.
REQ-042 cpu_re=1 and cpu_we=4'b1111 together: treated as a write (mem_req_rw = 1); cpu_dout unchanged.

Source files
------------

// File: rtl/dmem_cache_if.sv
// Core-side and main-memory-side signals of the direct-mapped data cache.
// master = core + memory model, slave = the cache itself.
interface dmem_cache_if;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output cpu_addr, cpu_re, cpu_we, cpu_din,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_dout, stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
    );

    modport slave (
        input  cpu_addr, cpu_re, cpu_we, cpu_din,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_dout, stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
    );
endinterface

// File: rtl/dmem_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// state   | meaning
// IDLE    | serve read hits with zero stall, launch misses and writes
// RD_REQ  | read request presented to main memory, waiting for ready
// RD_WAIT | waiting for the single-cycle read response, then fill
// WR_REQ  | write-through request presented, merge into line on hit
// DONE    | one stall-free cycle so the core retires the request
module dmem_cache #(
    parameter int LINES = 64
) (
    input logic         clk,
    input logic         reset,
    dmem_cache_if.slave bus
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 30 - IDX;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];
    logic [31:0]       dout_q;
    logic              req_valid_q;
    logic              req_rw_q;

    logic [IDX-1:0]    idx;
    logic [TW-1:0]     tag;
    logic              hit;
    logic              is_wr;
    logic              is_rd;
    logic              req;

    assign idx   = bus.cpu_addr[1+IDX:2];
    assign tag   = bus.cpu_addr[31:2+IDX];
    assign hit   = valid[idx] && (tag_mem[idx] == tag);
    assign is_wr = |bus.cpu_we;
    assign is_rd = bus.cpu_re && !is_wr;
    assign req   = is_wr || bus.cpu_re;

    // Stall in IDLE must react to the current request in the same cycle.
    always_comb begin
        bus.stall = 1'b0;
        case (state)
            IDLE:    bus.stall = req && !(is_rd && hit);
            DONE:    bus.stall = 1'b0;
            default: bus.stall = 1'b1;
        endcase
    end

    // Request fields come straight from the core, which holds them while stalled.
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_rw    = req_rw_q;
    assign bus.mem_req_addr  = bus.cpu_addr[31:2];
    assign bus.mem_req_data  = bus.cpu_din;
    assign bus.mem_req_mask  = bus.cpu_we;
    assign bus.cpu_dout      = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            dout_q      <= '0;
            req_valid_q <= 1'b0;
            req_rw_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_wr) begin
                        state       <= WR_REQ;
                        req_valid_q <= 1'b1;
                        req_rw_q    <= 1'b1;
                    end else if (is_rd && hit) begin
                        dout_q <= data_mem[idx];
                    end else if (is_rd) begin
                        state       <= RD_REQ;
                        req_valid_q <= 1'b1;
                        req_rw_q    <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (bus.mem_req_ready) begin
                        state       <= RD_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        valid[idx] <= 1'b1;
                        dout_q     <= bus.mem_resp_data;
                        state      <= DONE;
                    end
                end
                WR_REQ: begin
                    if (bus.mem_req_ready) begin
                        state       <= DONE;
                        req_valid_q <= 1'b0;
                        req_rw_q    <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; a line is only meaningful when valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == RD_WAIT && bus.mem_resp_valid) begin
                tag_mem[idx]  <= tag;
                data_mem[idx] <= bus.mem_resp_data;
            end else if (state == WR_REQ && bus.mem_req_ready && hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.cpu_we[b]) data_mem[idx][8*b +: 8] <= bus.cpu_din[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: expected cpu_dout queued at request issue,
// popped and checked when the request retires.
module tb_dmem_cache;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q [$];

    dmem_cache_if bus ();

    dmem_cache #(.LINES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request at the current negedge and plays main memory until it retires.
    task automatic run_req(
        input  string       name,
        input  logic [31:0] addr,
        input  logic        re,
        input  logic [3:0]  we,
        input  logic [31:0] din,
        input  int          rdy_dly,
        input  int          rsp_dly,
        input  logic [31:0] rsp_data,
        input  logic [31:0] exp_dout,
        output int          stall_n,
        output int          mreq_n,
        output logic        rw0,
        output logic [29:0] addr0,
        output logic [31:0] data0,
        output logic [3:0]  mask0,
        output logic        stable
    );
        int   vcnt = 0;
        int   wcnt = 0;
        bit   accepted = 0;
        bit   done = 0;
        logic v_s, r_s;
        logic [31:0] got;
        exp_q.push_back(exp_dout);
        bus.cpu_addr = addr;
        bus.cpu_re = re;
        bus.cpu_we = we;
        bus.cpu_din = din;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        stall_n = 0; mreq_n = 0; stable = 1'b1;
        rw0 = 1'b0; addr0 = '0; data0 = '0; mask0 = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            v_s = 1'b0; r_s = 1'b0;
            if (!bus.stall) begin
                done = 1;
            end else begin
                stall_n++;
                v_s = bus.mem_req_valid;
                if (v_s) begin
                    if (mreq_n == 0) begin
                        rw0 = bus.mem_req_rw; addr0 = bus.mem_req_addr;
                        data0 = bus.mem_req_data; mask0 = bus.mem_req_mask;
                    end else if (bus.mem_req_rw !== rw0 || bus.mem_req_addr !== addr0 ||
                                 bus.mem_req_data !== data0 || bus.mem_req_mask !== mask0) begin
                        stable = 1'b0;
                    end
                    mreq_n++;
                end
                r_s = v_s && (vcnt == rdy_dly);
                bus.mem_req_ready = r_s;
                bus.mem_resp_valid = accepted && (wcnt == rsp_dly);
                bus.mem_resp_data = rsp_data;
            end
            @(posedge clk);
            if (accepted) wcnt++;
            if (v_s && r_s) accepted = 1;
            if (v_s) vcnt++;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_resp_valid = 1'b0;
        end
        chk({name, "_timeout"}, 32'(done), 32'd1);
        got = exp_q.pop_front();
        chk({name, "_dout"}, bus.cpu_dout, got);
    endtask

    task automatic idle_cycle();
        bus.cpu_re = 1'b0;
        bus.cpu_we = 4'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    int          sn, mn;
    logic        rw, st;
    logic [29:0] ma;
    logic [31:0] md;
    logic [3:0]  mk;

    initial begin
        bus.cpu_addr = '0; bus.cpu_re = 1'b0; bus.cpu_we = '0; bus.cpu_din = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_dout", bus.cpu_dout, 32'h0);
        @(negedge clk);

        // Cold read miss, ready immediately, response on the second wait cycle.
        run_req("miss1", 32'h100, 1, 4'b0, 32'h0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, sn, mn, rw, ma, md, mk, st);
        chk("miss1_stall", 32'(sn), 32'd4);
        chk("miss1_mreq_n", 32'(mn), 32'd1);
        chk("miss1_addr", 32'(ma), 32'h40);
        chk("miss1_rw", 32'(rw), 32'd0);

        run_req("hit1", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hDEAD_BEEF, sn, mn, rw, ma, md, mk, st);
        chk("hit1_stall", 32'(sn), 32'd0);
        chk("hit1_mreq_n", 32'(mn), 32'd0);
        run_req("hit2", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hDEAD_BEEF, sn, mn, rw, ma, md, mk, st);
        chk("hit2_stall", 32'(sn), 32'd0);
        chk("hit2_mreq_n", 32'(mn), 32'd0);

        // Write hit, ready held low for three cycles.
        run_req("wr1", 32'h100, 0, 4'b0011, 32'h0000_1234, 3, 0, 32'h0, 32'hDEAD_BEEF, sn, mn, rw, ma, md, mk, st);
        chk("wr1_mreq_n", 32'(mn), 32'd4);
        chk("wr1_stall", 32'(sn), 32'd5);
        chk("wr1_stable", 32'(st), 32'd1);
        chk("wr1_rw", 32'(rw), 32'd1);
        chk("wr1_addr", 32'(ma), 32'h40);
        chk("wr1_data", md, 32'h0000_1234);
        chk("wr1_mask", 32'(mk), 32'h3);
        run_req("hit3", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hDEAD_1234, sn, mn, rw, ma, md, mk, st);
        chk("hit3_stall", 32'(sn), 32'd0);
        idle_cycle();

        // Conflict miss on the same index replaces the line.
        run_req("miss2", 32'h200, 1, 4'b0, 32'h0, 1, 0, 32'hAAAA_0200, 32'hAAAA_0200, sn, mn, rw, ma, md, mk, st);
        chk("miss2_stall", 32'(sn), 32'd4);
        chk("miss2_addr", 32'(ma), 32'h80);
        run_req("hit4", 32'h200, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hAAAA_0200, sn, mn, rw, ma, md, mk, st);
        chk("hit4_stall", 32'(sn), 32'd0);
        run_req("miss3", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h1111_2222, 32'h1111_2222, sn, mn, rw, ma, md, mk, st);
        chk("miss3_is_miss", 32'(sn > 0), 32'd1);

        // Read and write together behave as a write; cpu_dout is untouched.
        run_req("rw1", 32'h100, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 32'h0, 32'h1111_2222, sn, mn, rw, ma, md, mk, st);
        chk("rw1_rw", 32'(rw), 32'd1);
        chk("rw1_stall", 32'(sn), 32'd2);
        run_req("hit5", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hCAFE_F00D, sn, mn, rw, ma, md, mk, st);
        chk("hit5_stall", 32'(sn), 32'd0);

        // Write miss does not allocate or disturb the resident line.
        run_req("wrmiss", 32'h400, 0, 4'b1111, 32'h9999_9999, 2, 0, 32'h0, 32'hCAFE_F00D, sn, mn, rw, ma, md, mk, st);
        chk("wrmiss_addr", 32'(ma), 32'h100);
        run_req("hit6", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0, 32'hCAFE_F00D, sn, mn, rw, ma, md, mk, st);
        chk("hit6_stall", 32'(sn), 32'd0);
        idle_cycle();

        // Reset while in RD_WAIT, with the response arriving at and after the reset edge.
        bus.cpu_addr = 32'h300; bus.cpu_re = 1'b1; bus.cpu_we = 4'b0;
        @(posedge clk); @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.mem_req_ready = 1'b0;
        reset = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5555_5555;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        bus.cpu_re = 1'b0;
        #1;
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        chk("midrst_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("midrst_dout", bus.cpu_dout, 32'h0);
        @(posedge clk); @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        run_req("miss4", 32'h300, 1, 4'b0, 32'h0, 0, 0, 32'h0000_0077, 32'h0000_0077, sn, mn, rw, ma, md, mk, st);
        chk("miss4_is_miss", 32'(sn > 0), 32'd1);
        run_req("miss5", 32'h100, 1, 4'b0, 32'h0, 0, 0, 32'h0000_0088, 32'h0000_0088, sn, mn, rw, ma, md, mk, st);
        chk("miss5_is_miss", 32'(sn > 0), 32'd1);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
